// File: rtl/truth_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// truth_sweep_ctrl
//
// Purpose:
//   Drives an exhaustive sweep of all 2^N input vectors into two
//   implementations of the same Boolean function. It compares their outputs
//   once per vector and reports the mismatch count, the first failing vector
//   and an overall pass flag. Each vector is held for SETTLE+1 cycles. The
//   compare uses the last edge of that window.
//
// Parameters:
//   N       number of function inputs (the sweep covers 2^N vectors)
//   SETTLE  extra wait cycles per vector before the compare (0..15)
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high; returns to IDLE with outputs at 0
//   start         request a sweep; accepted only in IDLE
//   abort         cancel a sweep in progress (RUN only)
//   r_a, r_b      outputs of implementations A and B for the current vec
//   vec           registered input vector driven to both implementations
//   busy          high while sweeping (RUN)
//   done          one-cycle pulse at normal completion
//   mismatch_cnt  number of compared vectors where r_a != r_b
//   first_bad     first vector that mismatched
//   first_valid   first_bad holds a captured vector
//   pass          last sweep completed with zero mismatches
// -----------------------------------------------------------------------------
module truth_sweep_ctrl #(
  parameter int N      = 2,
  parameter int SETTLE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         r_a,
  input  logic         r_b,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic [N:0]   mismatch_cnt,
  output logic [N-1:0] first_bad,
  output logic         first_valid,
  output logic         pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0]   SETTLE_INIT = 4'(SETTLE);
  localparam logic [N-1:0] VEC_LAST    = '1;

  state_t       r_state,       w_state;
  logic [N-1:0] r_vec,         w_vec;
  logic [3:0]   r_settle,      w_settle;
  logic [N:0]   r_cnt,         w_cnt;
  logic [N-1:0] r_first_bad,   w_first_bad;
  logic         r_first_valid, w_first_valid;
  logic         r_pass,        w_pass;
  logic         w_mismatch;

  // r_a/r_b are outputs of the implementations for the current r_vec. They
  // are used directly, with no input register, so the compare sees the
  // response to the vector held during this window.
  assign w_mismatch = r_a ^ r_b;

  // Next-state and next-value logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so a path that
    // does not assign it cannot infer a latch.
    w_state       = r_state;
    w_vec         = r_vec;
    w_settle      = r_settle;
    w_cnt         = r_cnt;
    w_first_bad   = r_first_bad;
    w_first_valid = r_first_valid;
    w_pass        = r_pass;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state       = S_RUN;
          w_vec         = '0;
          w_settle      = SETTLE_INIT;
          w_cnt         = '0;
          w_first_bad   = '0;
          w_first_valid = 1'b0;
          w_pass        = 1'b0;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Partial results are kept. pass stays 0 from the start-accept.
          w_state = S_IDLE;
        end else if (r_settle != 4'd0) begin
          w_settle = r_settle - 4'd1;
        end else begin
          if (w_mismatch) begin
            w_cnt = r_cnt + 1'b1;
            if (!r_first_valid) begin
              w_first_bad   = r_vec;
              w_first_valid = 1'b1;
            end
          end
          if (r_vec == VEC_LAST) begin
            // pass uses the count that includes this final compare.
            w_state = S_DONE;
            w_pass  = (w_cnt == '0);
          end else begin
            w_vec    = r_vec + 1'b1;
            w_settle = SETTLE_INIT;
          end
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from the values sampled at the edge.
    if (reset) begin
      r_state       <= S_IDLE;
      r_vec         <= '0;
      r_settle      <= 4'd0;
      r_cnt         <= '0;
      r_first_bad   <= '0;
      r_first_valid <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_vec         <= w_vec;
      r_settle      <= w_settle;
      r_cnt         <= w_cnt;
      r_first_bad   <= w_first_bad;
      r_first_valid <= w_first_valid;
      r_pass        <= w_pass;
    end
  end

  assign vec          = r_vec;
  assign busy         = (r_state == S_RUN);
  assign done         = (r_state == S_DONE);
  assign mismatch_cnt = r_cnt;
  assign first_bad    = r_first_bad;
  assign first_valid  = r_first_valid;
  assign pass         = r_pass;

endmodule
